// File: rtl/urv_pkg.sv
// Shared definitions for the writeback stage: result-source encodings,
// load funct3 codes and the writeback state type.
package urv_pkg;

  localparam logic [1:0] RD_SOURCE_ALU  = 2'd0;
  localparam logic [1:0] RD_SOURCE_DIV  = 2'd1;
  localparam logic [1:0] RD_SOURCE_LOAD = 2'd2;

  localparam logic [2:0] FUNC_LB  = 3'd0;
  localparam logic [2:0] FUNC_LH  = 3'd1;
  localparam logic [2:0] FUNC_LW  = 3'd2;
  localparam logic [2:0] FUNC_LBU = 3'd4;
  localparam logic [2:0] FUNC_LHU = 3'd5;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/urv_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it according to the load funct3.
module urv_load_align
  import urv_pkg::*;
(
  input  logic [2:0]  fun,
  input  logic [1:0]  lsb,
  input  logic [31:0] raw,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Extract the addressed byte and half; lsb[0] is irrelevant for halves
  // because misaligned halfword accesses never reach this stage.
  always_comb begin
    byte_sel = raw[8*lsb +: 8];
    half_sel = lsb[1] ? raw[31:16] : raw[15:0];
  end

  // Extend the selected field; unknown funct3 codes load the full word.
  always_comb begin
    case (fun)
      FUNC_LB:  aligned = {{24{byte_sel[7]}}, byte_sel};
      FUNC_LBU: aligned = {24'h0, byte_sel};
      FUNC_LH:  aligned = {{16{half_sel[15]}}, half_sel};
      FUNC_LHU: aligned = {16'h0, half_sel};
      default:  aligned = raw;
    endcase
  end

endmodule

// File: rtl/urv_writeback.sv
// Writeback stage: registers the retiring result (ALU, divider or aligned
// load data), writes the register file, feeds the W->X bypass and holds
// the pipeline while a load is waiting for memory.
module urv_writeback
  import urv_pkg::*;
#(
  parameter int G_WITH_DIVIDER = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        x_rd_write_i,
  input  logic [4:0]  x_rd_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_div_result_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_lsb_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_req_o,
  output logic        rf_write_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_wdata_o,
  output logic        w_bypass_valid_o,
  output logic [4:0]  w_bypass_rd_o,
  output logic [31:0] w_bypass_value_o
);

  wb_state_t   state;
  logic [4:0]  rd_q;
  logic        rd_write_q;
  logic [2:0]  fun_q;
  logic [1:0]  lsb_q;

  logic        capture;
  logic        rd_write_eff;
  logic [31:0] exec_value;
  logic [31:0] load_aligned;

  // Capture qualification and result-source selection for non-load results.
  always_comb begin
    capture      = x_valid_i && !x_stall_i && !x_kill_i && (state == WB_IDLE);
    rd_write_eff = x_rd_write_i && (x_rd_i != 5'd0);
    exec_value   = x_rd_value_i;
    if (x_rd_source_i == RD_SOURCE_DIV)
      exec_value = (G_WITH_DIVIDER != 0) ? x_div_result_i : 32'h0;
  end

  urv_load_align u_load_align (
    .fun     (fun_q),
    .lsb     (lsb_q),
    .raw     (dm_data_l_i),
    .aligned (load_aligned)
  );

  // Writeback FSM: non-loads retire one cycle after capture; loads park in
  // LOAD_WAIT until memory returns, then retire one cycle after the done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= WB_IDLE;
      rd_q       <= 5'd0;
      rd_write_q <= 1'b0;
      fun_q      <= 3'd0;
      lsb_q      <= 2'd0;
      rf_write_o <= 1'b0;
      rf_rd_o    <= 5'd0;
      rf_wdata_o <= 32'h0;
    end else begin
      rf_write_o <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (capture) begin
            rd_q       <= x_rd_i;
            rd_write_q <= rd_write_eff;
            fun_q      <= x_fun_i;
            lsb_q      <= x_dm_addr_lsb_i;
            if (x_rd_source_i == RD_SOURCE_LOAD) begin
              state <= WB_LOAD_WAIT;
            end else begin
              rf_write_o <= rd_write_eff;
              rf_rd_o    <= x_rd_i;
              rf_wdata_o <= exec_value;
            end
          end
        end
        WB_LOAD_WAIT: begin
          if (dm_load_done_i) begin
            rf_write_o <= rd_write_q;
            rf_rd_o    <= rd_q;
            rf_wdata_o <= load_aligned;
            state      <= WB_IDLE;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  // Stall while the load is outstanding; bypass mirrors the registered write.
  always_comb begin
    w_stall_req_o    = (state == WB_LOAD_WAIT);
    w_bypass_valid_o = rf_write_o;
    w_bypass_rd_o    = rf_rd_o;
    w_bypass_value_o = rf_wdata_o;
  end

endmodule

// File: tb/tb_urv_writeback.sv
// Directed testbench for urv_writeback: ALU/divider/load writeback, x0
// suppression, kill/stall gating, reset during a pending load.
module tb_urv_writeback;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        x_valid_i, x_stall_i, x_kill_i, x_rd_write_i;
  logic [4:0]  x_rd_i;
  logic [1:0]  x_rd_source_i;
  logic [31:0] x_rd_value_i, x_div_result_i;
  logic [2:0]  x_fun_i;
  logic [1:0]  x_dm_addr_lsb_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;

  logic        w_stall_req_o, rf_write_o, w_bypass_valid_o;
  logic [4:0]  rf_rd_o, w_bypass_rd_o;
  logic [31:0] rf_wdata_o, w_bypass_value_o;

  logic        nd_stall, nd_write, nd_bvalid;
  logic [4:0]  nd_rd, nd_brd;
  logic [31:0] nd_wdata, nd_bvalue;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  urv_writeback #(.G_WITH_DIVIDER(1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .x_valid_i(x_valid_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .x_rd_write_i(x_rd_write_i), .x_rd_i(x_rd_i), .x_rd_source_i(x_rd_source_i),
    .x_rd_value_i(x_rd_value_i), .x_div_result_i(x_div_result_i),
    .x_fun_i(x_fun_i), .x_dm_addr_lsb_i(x_dm_addr_lsb_i),
    .dm_data_l_i(dm_data_l_i), .dm_load_done_i(dm_load_done_i),
    .w_stall_req_o(w_stall_req_o), .rf_write_o(rf_write_o), .rf_rd_o(rf_rd_o),
    .rf_wdata_o(rf_wdata_o), .w_bypass_valid_o(w_bypass_valid_o),
    .w_bypass_rd_o(w_bypass_rd_o), .w_bypass_value_o(w_bypass_value_o)
  );

  urv_writeback #(.G_WITH_DIVIDER(0)) dut_nodiv (
    .clk_i(clk), .rst_i(rst_i),
    .x_valid_i(x_valid_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .x_rd_write_i(x_rd_write_i), .x_rd_i(x_rd_i), .x_rd_source_i(x_rd_source_i),
    .x_rd_value_i(x_rd_value_i), .x_div_result_i(x_div_result_i),
    .x_fun_i(x_fun_i), .x_dm_addr_lsb_i(x_dm_addr_lsb_i),
    .dm_data_l_i(dm_data_l_i), .dm_load_done_i(dm_load_done_i),
    .w_stall_req_o(nd_stall), .rf_write_o(nd_write), .rf_rd_o(nd_rd),
    .rf_wdata_o(nd_wdata), .w_bypass_valid_o(nd_bvalid),
    .w_bypass_rd_o(nd_brd), .w_bypass_value_o(nd_bvalue)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    x_valid_i = 0; x_stall_i = 0; x_kill_i = 0; x_rd_write_i = 0;
    x_rd_i = 0; x_rd_source_i = 0; x_rd_value_i = 0; x_div_result_i = 0;
    x_fun_i = 0; x_dm_addr_lsb_i = 0; dm_data_l_i = 0; dm_load_done_i = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] val,
                       input logic [31:0] dval, input logic [2:0] fun, input logic [1:0] lsb);
    x_valid_i = 1; x_rd_write_i = 1; x_rd_i = rd; x_rd_source_i = src;
    x_rd_value_i = val; x_div_result_i = dval; x_fun_i = fun; x_dm_addr_lsb_i = lsb;
  endtask

  // Load with memory answering in the third cycle after capture.
  task automatic do_load(input string tag, input logic [2:0] fun, input logic [1:0] lsb,
                         input logic [31:0] data, input logic [4:0] rd, input logic [31:0] exp);
    int stall_cycles;
    stall_cycles = 0;
    issue(rd, 2'd2, 32'hDEAD_BEEF, 32'h0, fun, lsb);
    tick();
    idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      if (w_stall_req_o) stall_cycles++;
      check({tag, "_nowrite"}, {31'h0, rf_write_o}, 32'h0);
      if (k == 3) begin
        dm_data_l_i = data;
        dm_load_done_i = 1;
      end
      tick();
    end
    dm_load_done_i = 0;
    dm_data_l_i = 32'h0;
    check({tag, "_stall_cycles"}, stall_cycles, 32'd3);
    check({tag, "_stall_clear"}, {31'h0, w_stall_req_o}, 32'h0);
    check({tag, "_write"}, {31'h0, rf_write_o}, 32'h1);
    check({tag, "_rd"}, {27'h0, rf_rd_o}, {27'h0, rd});
    check({tag, "_data"}, rf_wdata_o, exp);
    tick();
    check({tag, "_pulse_end"}, {31'h0, rf_write_o}, 32'h0);
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    tick(); tick();
    check("rst_write", {31'h0, rf_write_o}, 32'h0);
    check("rst_stall", {31'h0, w_stall_req_o}, 32'h0);
    check("rst_wdata", rf_wdata_o, 32'h0);
    check("rst_bvalid", {31'h0, w_bypass_valid_o}, 32'h0);
    rst_i = 0;
    tick();

    // ALU result, latency 1, one-cycle pulse
    issue(5'd5, 2'd0, 32'h1234_5678, 32'h0, 3'd0, 2'd0);
    tick();
    idle_inputs();
    check("alu_write", {31'h0, rf_write_o}, 32'h1);
    check("alu_rd", {27'h0, rf_rd_o}, 32'd5);
    check("alu_data", rf_wdata_o, 32'h1234_5678);
    check("alu_bvalid", {31'h0, w_bypass_valid_o}, 32'h1);
    check("alu_brd", {27'h0, w_bypass_rd_o}, 32'd5);
    check("alu_bvalue", w_bypass_value_o, 32'h1234_5678);
    tick();
    check("alu_pulse_end", {31'h0, rf_write_o}, 32'h0);

    // x0 never written
    issue(5'd0, 2'd0, 32'hAAAA_5555, 32'h0, 3'd0, 2'd0);
    tick();
    idle_inputs();
    check("x0_write", {31'h0, rf_write_o}, 32'h0);
    check("x0_bvalid", {31'h0, w_bypass_valid_o}, 32'h0);

    // Divider source, with and without divider
    issue(5'd10, 2'd1, 32'h0000_DEAD, 32'hFFFF_FFFD, 3'd0, 2'd0);
    tick();
    idle_inputs();
    check("div_write", {31'h0, rf_write_o}, 32'h1);
    check("div_rd", {27'h0, rf_rd_o}, 32'd10);
    check("div_data", rf_wdata_o, 32'hFFFF_FFFD);
    check("nodiv_write", {31'h0, nd_write}, 32'h1);
    check("nodiv_data", nd_wdata, 32'h0);

    // Reserved source behaves as ALU
    issue(5'd11, 2'd3, 32'h0BAD_F00D, 32'h1111_1111, 3'd0, 2'd0);
    tick();
    idle_inputs();
    check("rsv_data", rf_wdata_o, 32'h0BAD_F00D);

    // Loads
    do_load("lb",   3'd0, 2'd3, 32'h80FF_0000, 5'd7,  32'hFFFF_FF80);
    do_load("lbu",  3'd4, 2'd3, 32'h80FF_0000, 5'd7,  32'h0000_0080);
    do_load("lhu",  3'd5, 2'd2, 32'hBEEF_1111, 5'd8,  32'h0000_BEEF);
    do_load("lh",   3'd1, 2'd0, 32'hBEEF_1111, 5'd9,  32'h0000_1111);
    do_load("lhn",  3'd1, 2'd3, 32'h8001_2345, 5'd9,  32'hFFFF_8001);
    do_load("lb1",  3'd0, 2'd1, 32'h0000_7F00, 5'd12, 32'h0000_007F);
    do_load("lw",   3'd2, 2'd0, 32'hCAFE_BABE, 5'd13, 32'hCAFE_BABE);
    do_load("f3lw", 3'd3, 2'd0, 32'h8765_4321, 5'd14, 32'h8765_4321);

    // Stray done pulse while idle
    dm_data_l_i = 32'h1234_0000; dm_load_done_i = 1;
    tick();
    idle_inputs();
    check("stray_done", {31'h0, rf_write_o}, 32'h0);

    // Kill and execute-stall gate capture
    issue(5'd3, 2'd0, 32'h5555_0000, 32'h0, 3'd0, 2'd0);
    x_kill_i = 1;
    tick();
    idle_inputs();
    check("kill_write", {31'h0, rf_write_o}, 32'h0);
    issue(5'd3, 2'd2, 32'h5555_0000, 32'h0, 3'd2, 2'd0);
    x_stall_i = 1;
    tick();
    idle_inputs();
    check("xstall_write", {31'h0, rf_write_o}, 32'h0);
    check("xstall_nowait", {31'h0, w_stall_req_o}, 32'h0);

    // Back-to-back ALU captures
    issue(5'd1, 2'd0, 32'h0000_0001, 32'h0, 3'd0, 2'd0);
    tick();
    check("b2b_first", {27'h0, rf_rd_o}, 32'd1);
    issue(5'd2, 2'd0, 32'h0000_0002, 32'h0, 3'd0, 2'd0);
    tick();
    idle_inputs();
    check("b2b_write", {31'h0, rf_write_o}, 32'h1);
    check("b2b_data", rf_wdata_o, 32'h0000_0002);

    // Reset during LOAD_WAIT, then a late done pulse
    issue(5'd20, 2'd2, 32'h0, 32'h0, 3'd2, 2'd0);
    tick();
    idle_inputs();
    check("rstld_stall", {31'h0, w_stall_req_o}, 32'h1);
    #2;
    rst_i = 1;
    #1;
    check("rstld_async", {31'h0, w_stall_req_o}, 32'h0);
    tick();
    rst_i = 0;
    dm_data_l_i = 32'hFFFF_FFFF; dm_load_done_i = 1;
    tick();
    idle_inputs();
    check("rstld_late_done", {31'h0, rf_write_o}, 32'h0);
    check("rstld_stall_off", {31'h0, w_stall_req_o}, 32'h0);
    tick();
    check("rstld_no_write", {31'h0, rf_write_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/urv_writeback.md
Name: urv_writeback

Overview:
- Final pipeline stage of the core. It sits directly downstream of the execute stage and the iterative divider.
- Registers the retiring instruction's result, selected from: ALU result, divider result (divider x_rd_o), or load data.
- Aligns and sign-extends load data returning from data memory, writes the register file, and drives the W->X bypass path.
- Requests a pipeline stall while a load's data is outstanding.

Parameters:
- G_WITH_DIVIDER, 1, when 0 the DIV source returns 32'h0 and x_div_result_i is ignored.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-high
- x_valid_i  in  1  execute stage holds a valid instruction
- x_stall_i  in  1  execute stage stalled (includes divider stall); instruction advances only when low
- x_kill_i  in  1  instruction in execute is squashed
- x_rd_write_i  in  1  instruction writes rd
- x_rd_i  in  5  destination register
- x_rd_source_i  in  2  0=ALU, 1=DIV, 2=LOAD, 3=reserved (treated as ALU)
- x_rd_value_i  in  32  ALU/CSR result
- x_div_result_i  in  32  divider result (registered, stable when divider done)
- x_fun_i  in  3  load funct3: 0=LB 1=LH 2=LW 4=LBU 5=LHU
- x_dm_addr_lsb_i  in  2  load address bits [1:0]
- dm_data_l_i  in  32  data-memory read data
- dm_load_done_i  in  1  one-cycle pulse: dm_data_l_i valid
- w_stall_req_o  out  1  stall request to upstream
- rf_write_o  out  1  register-file write enable
- rf_rd_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- w_bypass_valid_o  out  1  bypass value usable
- w_bypass_rd_o  out  5  bypass register
- w_bypass_value_o  out  32  bypass value

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0; captured fields cleared. Reset mid-load abandons the load; a later dm_load_done_i pulse is ignored.
- Capture condition: x_valid_i && !x_stall_i && !x_kill_i && state==IDLE. Latches rd, rd_write, source, fun, addr_lsb. Value is x_rd_value_i or x_div_result_i, per source.
- x_rd_i==0 forces the captured rd_write to 0. There are never writes to x0.
- States:
  - IDLE: a captured non-load with rd_write=1 produces rf_write_o=1 on the next cycle, for exactly 1 cycle (latency 1). A captured load goes to LOAD_WAIT.
  - LOAD_WAIT: w_stall_req_o=1 combinationally. Capture is inhibited; upstream must hold.
    - On dm_load_done_i=1: the same cycle registers the aligned data, clears the stall, and goes to IDLE.
    - rf_write_o pulses the following cycle (load latency = memory latency + 1).
- Load alignment:
  - Byte: byte dm_data_l_i[8*lsb+:8].
  - Half: half selected by lsb[1]; lsb[0] is ignored (misalignment is trapped upstream).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW uses the whole word.
  - Any other funct3 is treated as LW.
- A killed or invalid instruction produces no write and no state change.
- dm_load_done_i outside LOAD_WAIT is ignored.
- Bypass:
  - w_bypass_rd_o/value_o mirror the registered rf outputs.
  - w_bypass_valid_o = rf_write_o. It is 0 during LOAD_WAIT; upstream must interlock on load-use.
- Back-to-back: a capture in the same cycle as an rf_write_o pulse is legal (full throughput for non-loads).
- Bit 32 of the divider path is never consumed; only 32-bit values are stored.

Decomposition:
- Shared defs: rd_source encodings (RD_SOURCE_ALU/DIV/LOAD) and the FUNC_LB/LH/LW/LBU/LHU constants go beside the existing FUNC_* defines in kmkz_defs.v.
- One natural combinational sub-module: urv_load_align (funct3, lsb, raw data -> aligned 32-bit word).

Test Plan:
1. ALU result: x_rd_i=5, value 32'h1234_5678, source ALU -> next cycle rf_write_o=1, rf_rd_o=5, rf_wdata_o=32'h1234_5678, pulse 1 cycle.
2. x0 suppression: x_rd_i=0, rd_write=1 -> rf_write_o stays 0, w_bypass_valid_o=0.
3. Divider: source DIV, x_div_result_i=32'hFFFF_FFFD (-7/2 quotient) -> written to rd 10. With G_WITH_DIVIDER=0 -> writes 32'h0.
4. LB, lsb=3, dm_data_l_i=32'h80FF_0000, done 3 cycles after capture:
   - w_stall_req_o high for exactly 3 cycles.
   - rf_wdata_o=32'hFFFF_FF80 one cycle after done.
   - With LBU instead -> 32'h0000_0080.
5. LHU, lsb=2, data 32'hBEEF_1111 -> 32'h0000_BEEF. LH with lsb=0 -> 32'h0000_1111.
6. Reset asserted during LOAD_WAIT, then a late done pulse -> no rf write, stall deasserted asynchronously. Kill during capture -> no write.
